// File: rtl/alu_result_queue.sv
// ALU result selector with sign/zero extension, status flags and a 2-entry
// valid/ready output queue; counts delivered results with saturation.
module alu_result_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGNED_EXT = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                opcode,
  input  logic [DATA_WIDTH:0]       result_sum,
  input  logic [DATA_WIDTH:0]       result_res,
  input  logic [2*DATA_WIDTH-1:0]   result_pro,
  input  logic [DATA_WIDTH-1:0]     result_and,
  input  logic [DATA_WIDTH-1:0]     result_or,
  input  logic [DATA_WIDTH-1:0]     result_nand,
  input  logic [DATA_WIDTH-1:0]     result_nor,
  input  logic [DATA_WIDTH-1:0]     result_xor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   data,
  output logic                      flag_zero,
  output logic                      flag_neg,
  output logic                      flag_carry,
  output logic [CNT_WIDTH-1:0]      result_cnt
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned DW = 2 * DATA_WIDTH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          zero;
    logic          neg;
    logic          carry;
  } entry_t;

  logic [1:0]           count_q, count_d;
  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DW-1:0] ext_c;
  logic          carry_c;
  entry_t        new_c;
  logic          push_c, pop_c;

  // Opcode select and extension to 2W
  always_comb begin
    ext_c   = '0;
    carry_c = 1'b0;
    case (opcode)
      3'b000: begin
        ext_c   = {{(W-1){SIGNED_EXT & result_sum[W]}}, result_sum};
        carry_c = result_sum[W];
      end
      3'b001: begin
        ext_c   = {{(W-1){SIGNED_EXT & result_res[W]}}, result_res};
        carry_c = result_res[W];
      end
      3'b010: ext_c = result_pro;
      3'b011: ext_c = {{W{1'b0}}, result_and};
      3'b100: ext_c = {{W{1'b0}}, result_or};
      3'b101: ext_c = {{W{1'b0}}, result_nand};
      3'b110: ext_c = {{W{1'b0}}, result_nor};
      3'b111: ext_c = {{W{1'b0}}, result_xor};
      default: ext_c = '0;
    endcase
  end

  always_comb begin
    new_c.data  = ext_c;
    new_c.zero  = (ext_c == '0);
    new_c.neg   = ext_c[DW-1];
    new_c.carry = carry_c;
  end

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Queue next-state; flush overrides push and pop
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_c) begin
            head_d  = new_c;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push_c && pop_c) begin
            head_d = new_c;
          end else if (pop_c) begin
            count_d = 2'd0;
          end else if (push_c) begin
            tail_d  = new_c;
            count_d = 2'd2;
          end
        end
        2'd2: begin
          if (pop_c) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
      if (pop_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
    out_valid_d = (count_d != 2'd0);
    in_ready_d  = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign data       = head_q.data;
  assign flag_zero  = head_q.zero;
  assign flag_neg   = head_q.neg;
  assign flag_carry = head_q.carry;
  assign result_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: three instances (signed, zero-extend, 2-bit counter)
// share one stimulus and are compared with a queue-based reference model.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  opcode;
  logic [8:0]  result_sum, result_res;
  logic [15:0] result_pro;
  logic [7:0]  result_and, result_or, result_nand, result_nor, result_xor;

  logic        in_ready, out_valid, flag_zero, flag_neg, flag_carry;
  logic [15:0] data, result_cnt;
  logic        in_ready_z, out_valid_z, flag_zero_z, flag_neg_z, flag_carry_z;
  logic [15:0] data_z, result_cnt_z;
  logic        in_ready_c, out_valid_c, flag_zero_c, flag_neg_c, flag_carry_c;
  logic [15:0] data_c;
  logic [1:0]  result_cnt_c;

  always #5 clk = ~clk;

  alu_result_queue #(.DATA_WIDTH(8), .SIGNED_EXT(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .result_sum(result_sum), .result_res(result_res), .result_pro(result_pro),
    .result_and(result_and), .result_or(result_or), .result_nand(result_nand),
    .result_nor(result_nor), .result_xor(result_xor), .out_valid(out_valid),
    .out_ready(out_ready), .data(data), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .flag_carry(flag_carry), .result_cnt(result_cnt));

  alu_result_queue #(.DATA_WIDTH(8), .SIGNED_EXT(1'b0), .CNT_WIDTH(16)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .opcode(opcode), .result_sum(result_sum), .result_res(result_res), .result_pro(result_pro),
    .result_and(result_and), .result_or(result_or), .result_nand(result_nand),
    .result_nor(result_nor), .result_xor(result_xor), .out_valid(out_valid_z),
    .out_ready(out_ready), .data(data_z), .flag_zero(flag_zero_z), .flag_neg(flag_neg_z),
    .flag_carry(flag_carry_z), .result_cnt(result_cnt_z));

  alu_result_queue #(.DATA_WIDTH(8), .SIGNED_EXT(1'b1), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
    .opcode(opcode), .result_sum(result_sum), .result_res(result_res), .result_pro(result_pro),
    .result_and(result_and), .result_or(result_or), .result_nand(result_nand),
    .result_nor(result_nor), .result_xor(result_xor), .out_valid(out_valid_c),
    .out_ready(out_ready), .data(data_c), .flag_zero(flag_zero_c), .flag_neg(flag_neg_c),
    .flag_carry(flag_carry_c), .result_cnt(result_cnt_c));

  // Reference model: expected entry per push, for both extension modes
  typedef struct {
    logic [15:0] ds, du;
    bit          zs, ns, zu, nu, c;
  } mentry_t;

  mentry_t mq[$];
  mentry_t shown;
  int      ndeliv;
  int      checks = 0;
  int      errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] val;
    logic [15:0] exp_data;
    bit          exp_z, exp_n, exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic mentry_t make_entry();
    mentry_t e;
    logic [15:0] s, u;
    bit c;
    c = 1'b0;
    case (opcode)
      3'd0: begin s = 16'($signed(result_sum)); u = 16'(result_sum); c = result_sum[8]; end
      3'd1: begin s = 16'($signed(result_res)); u = 16'(result_res); c = result_res[8]; end
      3'd2: begin s = result_pro; u = result_pro; end
      3'd3: begin s = 16'(result_and);  u = s; end
      3'd4: begin s = 16'(result_or);   u = s; end
      3'd5: begin s = 16'(result_nand); u = s; end
      3'd6: begin s = 16'(result_nor);  u = s; end
      default: begin s = 16'(result_xor); u = s; end
    endcase
    e.ds = s; e.du = u; e.c = c;
    e.zs = (s == 16'd0); e.ns = s[15];
    e.zu = (u == 16'd0); e.nu = u[15];
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    ndeliv = 0;
    shown = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  // Applied at each rising edge using the inputs held across that edge
  task automatic model_edge();
    bit push, pop;
    if (!rst_n) return;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        ndeliv++;
      end
      if (push) mq.push_back(make_entry());
    end
    if (mq.size() > 0) shown = mq[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " out_valid"},  32'(out_valid),    32'(mq.size() > 0));
    chk({tag, " in_ready"},   32'(in_ready),     32'(mq.size() < 2));
    chk({tag, " data"},       32'(data),         32'(shown.ds));
    chk({tag, " zero"},       32'(flag_zero),    32'(shown.zs));
    chk({tag, " neg"},        32'(flag_neg),     32'(shown.ns));
    chk({tag, " carry"},      32'(flag_carry),   32'(shown.c));
    chk({tag, " cnt"},        32'(result_cnt),   32'((ndeliv > 65535) ? 65535 : ndeliv));
    chk({tag, " data_z"},     32'(data_z),       32'(shown.du));
    chk({tag, " zero_z"},     32'(flag_zero_z),  32'(shown.zu));
    chk({tag, " neg_z"},      32'(flag_neg_z),   32'(shown.nu));
    chk({tag, " cnt_c"},      32'(result_cnt_c), 32'((ndeliv > 3) ? 3 : ndeliv));
  endtask

  task automatic rand_buses();
    opcode      = 3'($urandom);
    result_sum  = 9'($urandom);
    result_res  = 9'($urandom);
    result_pro  = 16'($urandom);
    result_and  = 8'($urandom);
    result_or   = 8'($urandom);
    result_nand = 8'($urandom);
    result_nor  = 8'($urandom);
    result_xor  = 8'($urandom);
  endtask

  task automatic set_op(input logic [2:0] op, input logic [15:0] v);
    rand_buses();
    opcode = op;
    case (op)
      3'd0: result_sum  = 9'(v);
      3'd1: result_res  = 9'(v);
      3'd2: result_pro  = v;
      3'd3: result_and  = 8'(v);
      3'd4: result_or   = 8'(v);
      3'd5: result_nand = 8'(v);
      3'd6: result_nor  = 8'(v);
      default: result_xor = 8'(v);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    bit   accepted;
    int   saved_cnt;
    logic [15:0] v;

    vecs.push_back('{3'd0, 16'h01FF, 16'hFFFF, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 16'h007F, 16'h007F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 16'h0100, 16'hFF00, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{3'd1, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 16'h3039, 16'h3039, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd4, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 16'h00A5, 16'h00A5, 1'b0, 1'b0, 1'b0});

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_buses();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table: push each vector into the empty queue, then pop it
    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].val);
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check_outputs("tbl push");
      chk("tbl data",  32'(data),       32'(vecs[i].exp_data));
      chk("tbl zero",  32'(flag_zero),  32'(vecs[i].exp_z));
      chk("tbl neg",   32'(flag_neg),   32'(vecs[i].exp_n));
      chk("tbl carry", 32'(flag_carry), 32'(vecs[i].exp_c));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_outputs("tbl pop");
      if (i < 5) chk("sat cnt_c", 32'(result_cnt_c), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    // Zero-extension instance on an all-ones adder result
    set_op(3'd0, 16'h01FF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("zext data",  32'(data_z),       32'h01FF);
    chk("zext neg",   32'(flag_neg_z),   32'd0);
    chk("zext carry", 32'(flag_carry_z), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_outputs("zext pop");

    // Backpressure: third entry held by producer until accepted
    set_op(3'd7, 16'h00A5); in_valid = 1'b1; tick(); check_outputs("bp 1");
    set_op(3'd4, 16'h000F); tick(); check_outputs("bp 2");
    chk("bp full in_ready", 32'(in_ready), 32'd0);
    set_op(3'd6, 16'h0011); tick(); check_outputs("bp 3 held");
    chk("bp head", 32'(data), 32'h00A5);
    out_ready = 1'b1;
    tick(); check_outputs("bp pop1");
    chk("bp second head", 32'(data), 32'h000F);
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      accepted = in_ready;
      tick();
      check_outputs("bp drain");
    end
    in_valid = 1'b0;
    chk("bp third accepted", 32'(accepted), 32'd1);
    chk("bp third head", 32'(data), 32'h0011);
    tick(); check_outputs("bp empty");
    out_ready = 1'b0;

    // Push and pop every cycle at occupancy one
    set_op(3'd7, 16'h0003); in_valid = 1'b1; tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      v = 16'(k * 17 + 3) & 16'h00FF;
      set_op(3'd7, v);
      tick();
      check_outputs("pp");
      chk("pp order", 32'(data), 32'(v));
    end
    in_valid = 1'b0;
    tick(); check_outputs("pp drain");
    out_ready = 1'b0;

    // Flush with a full queue and a pending push
    set_op(3'd4, 16'h0055); in_valid = 1'b1; tick();
    set_op(3'd4, 16'h0066); tick();
    saved_cnt = ndeliv;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_outputs("flush");
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush cnt", 32'(result_cnt), 32'(saved_cnt));

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_buses();
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(19) == 0);
      tick();
      check_outputs("rand");
    end
    flush = 1'b0;

    // Asynchronous reset between clock edges with a non-empty queue
    set_op(3'd2, 16'hBEEF); in_valid = 1'b1; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_outputs("after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
